// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses SYNC/LEN/payload/CSUM frames, writes
// little-endian words, and holds the core in reset until the image verifies. Optional macro: LOADER_TIMEOUT_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    if (MAX_WORDS < 1 || MAX_WORDS > 65535) begin : g_bad_max_words
        $error("imem_loader: MAX_WORDS must be in 1..65535");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("imem_loader: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        byte_ready_q, byte_ready_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic [7:0]  csum_q, csum_d;

    logic        accept;
    logic [15:0] len_full;
    logic        is_sync;
    logic        restart;

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_active;
`endif

    assign accept   = byte_valid && byte_ready_q;
    assign len_full = {byte_data, len_q[7:0]};
    assign is_sync  = (byte_data == SYNC_BYTE);
    assign restart  = accept && is_sync &&
                      (state_q == ST_SYNC || state_q == ST_DONE || state_q == ST_ERR);

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        byte_ready_d = 1'b1;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        lane_d       = lane_q;
        word_buf_d   = word_buf_q;
        csum_d       = csum_q;

        if (restart) begin
            state_d    = ST_LEN0;
            len_d      = '0;
            word_cnt_d = '0;
            lane_d     = '0;
            word_buf_d = '0;
            csum_d     = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_LEN0: begin
                    len_d   = {8'h00, byte_data};
                    state_d = ST_LEN1;
                end
                ST_LEN1: begin
                    len_d = len_full;
                    if ({16'h0000, len_full} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_d = csum_q ^ byte_data;
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: word_buf_d[7:0]   = byte_data;
                        2'd1: word_buf_d[15:8]  = byte_data;
                        2'd2: word_buf_d[23:16] = byte_data;
                        2'd3: begin
                            // Fourth byte completes the word; the strobe cycle blocks the next byte.
                            imem_we_d    = 1'b1;
                            byte_ready_d = 1'b0;
                            imem_wdata_d = {byte_data, word_buf_q};
                            imem_addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                            word_cnt_d   = word_cnt_q + 16'd1;
                            if (word_cnt_q == len_q - 16'd1) begin
                                state_d = ST_CSUM;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_CSUM: begin
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                end
                default: ;
            endcase
        end

`ifdef LOADER_TIMEOUT_EN
        tmo_active = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
        tmo_d      = tmo_q;
        if (accept) begin
            tmo_d = '0;
        end else if (tmo_active) begin
            if (tmo_q == TIMEOUT_CYCLES - 1) begin
                tmo_d   = '0;
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif

        cpu_rst_d   = (state_d != ST_DONE);
        load_done_d = (state_d == ST_DONE);
        load_err_d  = (state_d == ST_ERR);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            byte_ready_q <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            lane_q       <= '0;
            word_buf_q   <= '0;
            csum_q       <= '0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            lane_q       <= lane_d;
            word_buf_q   <= word_buf_d;
            csum_q       <= csum_d;
`ifdef LOADER_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule
